uart_packet_parser: RTL and testbench
=====================================

# uart_packet_parser

Byte-stream framer directly downstream of the UART receiver. Consumes the receiver's one-cycle byte strobes, hunts for a sync byte, captures a length-prefixed payload into an internal buffer, validates it, and replays the accepted payload as a valid/ready byte stream with a last flag to the puzzle-loading logic. Malformed, oversized or stalled frames are discarded and reported with a one-cycle error pulse.

## Interface
- MAX_LEN, 64: maximum payload bytes per frame; buffer depth.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 50_000: idle clk cycles allowed between bytes inside a frame.

- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- axiiv  in  1  byte strobe from UART receiver; one-cycle pulse, no backpressure.
- axiid  in  8  received byte; valid only when axiiv=1.
- axiov  out  1  output byte valid.
- axiod  out  8  output payload byte.
- axiolast  out  1  marks final payload byte; qualified by axiov.
- axiordy  in  1  downstream ready.
- pkt_err  out  1  one-cycle pulse on frame rejection.
- busy  out  1  high in any state other than SYNC.

## Operation
- Frame: SYNC_BYTE, LEN (1..MAX_LEN), LEN payload bytes, CHK (only with CHECKSUM_EN). CHK = XOR of LEN and all payload bytes.
- States: SYNC, LEN, PAYLOAD, CHECK, LOAD, DRAIN.
- SYNC: strobes with axiid != SYNC_BYTE ignored; SYNC_BYTE -> LEN.
- LEN: strobe with axiid==0 or >MAX_LEN -> pkt_err, SYNC. Otherwise store len, clear wr_ptr, seed running XOR with LEN -> PAYLOAD.
- PAYLOAD: each strobe writes buf[wr_ptr], XORs into running sum, wr_ptr++. On the len-th byte -> CHECK (CHECKSUM_EN) or LOAD.
- CHECK: next strobe compared to running XOR; match -> LOAD, mismatch -> pkt_err, SYNC.
- LOAD: one cycle; registers buf[0] to axiod, axiov<=1, axiolast<=(len==1), rd_ptr<=1 -> DRAIN.
- DRAIN: on axiov&&axiordy: if axiolast, axiov<=0, axiolast<=0 -> SYNC; else axiod<=buf[rd_ptr], rd_ptr++, axiolast<=(rd_ptr==len-1). axiod/axiolast held stable while axiov&&!axiordy.
- Strobes arriving in LOAD/DRAIN are discarded silently; a SYNC_BYTE during DRAIN does not start a frame.
- Timeout: counter cleared on every strobe and on entry to LEN; in LEN/PAYLOAD/CHECK, reaching TIMEOUT_CYCLES -> pkt_err, SYNC. Counter idle in other states.
- Widths: wr_ptr/rd_ptr/len are $clog2(MAX_LEN+1) bits; timeout counter $clog2(TIMEOUT_CYCLES+1) bits.

## Timing
- Reset values: axiov=0, axiod=0, axiolast=0, pkt_err=0, busy=0, state SYNC, pointers, XOR and timeout counter 0. Reset mid-frame or mid-drain abandons the frame with no pkt_err; buffer contents need not clear.
- pkt_err rises the cycle after the offending strobe or timeout expiry; high exactly one cycle.
- axiov rises 2 cycles after the final strobe (CHK, or last payload byte without CHECKSUM_EN).
- Throughput in DRAIN: one byte per cycle with axiordy held high; LEN bytes take LEN cycles.
- busy falls the cycle after the last handshake; next SYNC_BYTE strobe accepted from that cycle.
- axiordy ignored while axiov=0.

## Configuration
- CHECKSUM_PKT_EN defined: CHK byte expected, CHECK state present, mismatch rejects frame.
- Undefined: no CHK byte; PAYLOAD goes directly to LOAD; running XOR and CHECK state removed; pkt_err only for bad LEN or timeout.

## Test plan
- Good frame A5 03 11 22 33 03, axiordy=1 -> axiod 11,22,33 on consecutive cycles, axiolast with 33, axiov rises 2 cycles after CHK strobe, no pkt_err.
- Same frame with CHK=04 -> single pkt_err pulse, axiov never asserts, following good frame accepted normally.
- A5 00 and A5 41 (MAX_LEN=64) -> pkt_err after LEN strobe, return to SYNC; stray bytes 00 FF before A5 ignored.
- Good 3-byte frame with axiordy pattern 0,1,0,0,1,1 -> each byte held stable until handshake, exactly 3 transfers, bytes A5 xx sent during DRAIN dropped.
- A5 02 11 then silence for TIMEOUT_CYCLES -> pkt_err, busy falls; with TIMEOUT_CYCLES=100 verify no error at 99 idle cycles.
- rst asserted during DRAIN after first byte -> next cycle axiov=0, busy=0, no pkt_err; subsequent frame A5 01 7E 7F outputs 7E with axiolast.

Source files
------------

// File: rtl/uart_packet_parser.sv
// Frames UART receiver bytes (SYNC, LEN, payload[, CHK]) into a buffer and replays accepted payloads as a valid/ready stream.
// Optional checksum byte and CHECK state are enabled with `define CHECKSUM_PKT_EN.
module uart_packet_parser #(
    parameter int          MAX_LEN        = 64,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [7:0] axiid,
    output logic       axiov,
    output logic [7:0] axiod,
    output logic       axiolast,
    input  logic       axiordy,
    output logic       pkt_err,
    output logic       busy,
    output logic [2:0] o_dbg_state
);
    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [8:0] MAX_LEN9 = 9'(MAX_LEN);

    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
`ifdef CHECKSUM_PKT_EN
        S_CHECK   = 3'd3,
`endif
        S_LOAD    = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    state_t          r_state, w_next;
    logic            w_err;
    logic            w_tmo_hit;
    logic            w_last_wr;
    logic            w_hs;
    logic [PW-1:0]   r_len, r_wr_ptr, r_rd_ptr;
    logic [TW-1:0]   r_tmo;
    logic [7:0]      r_buf [MAX_LEN];
    logic            r_axiov, r_axiolast, r_pkt_err;
    logic [7:0]      r_axiod;
`ifdef CHECKSUM_PKT_EN
    logic [7:0]      r_xor;
`endif

    assign w_tmo_hit  = !axiiv && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_last_wr  = (r_wr_ptr == r_len - PW'(1));
    assign w_hs       = r_axiov && axiordy;

    // Valid/ready: a byte transfers on any cycle where axiov && axiordy; axiod/axiolast hold while stalled.
    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            S_SYNC: begin
                if (axiiv && axiid == SYNC_BYTE) w_next = S_LEN;
            end
            S_LEN: begin
                if (axiiv) begin
                    if (axiid == 8'd0 || {1'b0, axiid} > MAX_LEN9) begin
                        w_err  = 1'b1;
                        w_next = S_SYNC;
                    end else begin
                        w_next = S_PAYLOAD;
                    end
                end else if (w_tmo_hit) begin
                    w_err  = 1'b1;
                    w_next = S_SYNC;
                end
            end
            S_PAYLOAD: begin
                if (axiiv && w_last_wr) begin
`ifdef CHECKSUM_PKT_EN
                    w_next = S_CHECK;
`else
                    w_next = S_LOAD;
`endif
                end else if (w_tmo_hit) begin
                    w_err  = 1'b1;
                    w_next = S_SYNC;
                end
            end
`ifdef CHECKSUM_PKT_EN
            S_CHECK: begin
                if (axiiv) begin
                    if (axiid == r_xor) begin
                        w_next = S_LOAD;
                    end else begin
                        w_err  = 1'b1;
                        w_next = S_SYNC;
                    end
                end else if (w_tmo_hit) begin
                    w_err  = 1'b1;
                    w_next = S_SYNC;
                end
            end
`endif
            S_LOAD:  w_next = S_DRAIN;
            S_DRAIN: begin
                if (w_hs && r_axiolast) w_next = S_SYNC;
            end
            default: w_next = S_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_SYNC;
            r_pkt_err  <= 1'b0;
            r_len      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tmo      <= '0;
            r_axiov    <= 1'b0;
            r_axiod    <= 8'd0;
            r_axiolast <= 1'b0;
`ifdef CHECKSUM_PKT_EN
            r_xor      <= 8'd0;
`endif
        end else begin
            r_state   <= w_next;
            r_pkt_err <= w_err;
            // Counter only runs while a frame is being received; any strobe restarts it.
            if (axiiv || r_state == S_SYNC || r_state == S_LOAD || r_state == S_DRAIN)
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + TW'(1);
            case (r_state)
                S_LEN: begin
                    if (axiiv) begin
                        r_len    <= PW'(axiid);
                        r_wr_ptr <= '0;
`ifdef CHECKSUM_PKT_EN
                        r_xor    <= axiid;
`endif
                    end
                end
                S_PAYLOAD: begin
                    if (axiiv) begin
                        r_wr_ptr <= r_wr_ptr + PW'(1);
`ifdef CHECKSUM_PKT_EN
                        r_xor    <= r_xor ^ axiid;
`endif
                    end
                end
                S_LOAD: begin
                    r_axiod    <= r_buf[0];
                    r_axiov    <= 1'b1;
                    r_axiolast <= (r_len == PW'(1));
                    r_rd_ptr   <= PW'(1);
                end
                S_DRAIN: begin
                    if (w_hs) begin
                        if (r_axiolast) begin
                            r_axiov    <= 1'b0;
                            r_axiolast <= 1'b0;
                        end else begin
                            r_axiod    <= r_buf[r_rd_ptr[AW-1:0]];
                            r_rd_ptr   <= r_rd_ptr + PW'(1);
                            r_axiolast <= (r_rd_ptr == r_len - PW'(1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer has no reset so it can map onto plain memory.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_PAYLOAD && axiiv)
            r_buf[r_wr_ptr[AW-1:0]] <= axiid;
    end

    assign axiov       = r_axiov;
    assign axiod       = r_axiod;
    assign axiolast    = r_axiolast;
    assign pkt_err     = r_pkt_err;
    assign busy        = (r_state != S_SYNC);
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_uart_packet_parser.sv
// Scoreboard bench for uart_packet_parser: expected payload bytes are queued as frames are sent and popped on each handshake.
// Honours `define CHECKSUM_PKT_EN to append the CHK byte to every frame.
module tb_uart_packet_parser;
  logic       clk = 1'b0;
  logic       rst;
  logic       axiiv;
  logic [7:0] axiid;
  logic       axiov;
  logic [7:0] axiod;
  logic       axiolast;
  logic       axiordy;
  logic       pkt_err;
  logic       busy;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer = 0;
  int n_pkterr = 0;

  logic [8:0] exp_q[$];
  logic [7:0] pay [0:63];

  uart_packet_parser #(
    .MAX_LEN(64),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axiiv(axiiv),
    .axiid(axiid),
    .axiov(axiov),
    .axiod(axiod),
    .axiolast(axiolast),
    .axiordy(axiordy),
    .pkt_err(pkt_err),
    .busy(busy),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    axiiv = 1'b1;
    axiid = b;
    tick();
    axiiv = 1'b0;
    axiid = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] len_b, input int n, input logic bad_chk, input logic push);
    logic [7:0] x;
    x = len_b;
    send_byte(8'hA5);
    send_byte(len_b);
    for (int i = 0; i < n; i++) begin
      x = x ^ pay[i];
      if (push) exp_q.push_back({(i == n - 1), pay[i]});
      send_byte(pay[i]);
    end
`ifdef CHECKSUM_PKT_EN
    send_byte(x ^ {7'd0, bad_chk});
`endif
  endtask

  task automatic wait_idle(input logic rnd, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!busy && exp_q.size() == 0) break;
      if (rnd) axiordy = 1'($urandom_range(0, 1));
      tick();
    end
    axiordy = 1'b1;
    check("idle_busy", busy, 0);
    check("idle_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: handshake scoreboard, hold-stability under backpressure, pkt_err pulse count.
  logic       stalled = 1'b0;
  logic [8:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (axiov) begin
        if (stalled) check("hold_stable", {axiolast, axiod}, held);
        if (axiordy) begin
          check("xfer_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("xfer_data", {axiolast, axiod}, exp_q.pop_front());
          n_xfer++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = {axiolast, axiod};
        end
      end else begin
        stalled = 1'b0;
      end
      if (pkt_err) n_pkterr++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int x0;
    int k;
    logic [5:0] pat;

    rst = 1'b1;
    axiiv = 1'b0;
    axiid = 8'h00;
    axiordy = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_axiov", axiov, 0);
    check("rst_axiod", axiod, 0);
    check("rst_axiolast", axiolast, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_busy", busy, 0);

    // Good frame A5 03 11 22 33 [03]: latency and one byte per cycle.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    e0 = n_pkterr;
    send_frame(8'h03, 3, 1'b0, 1'b1);
    check("lat_axiov_1", axiov, 0);
    tick();
    check("lat_axiov_2", axiov, 1);
    check("first_byte", axiod, 8'h11);
    x0 = n_xfer;
    repeat (3) tick();
    check("burst_xfers", n_xfer - x0, 3);
    check("burst_busy_fell", busy, 0);
    check("good_no_err", n_pkterr - e0, 0);
    wait_idle(1'b0, 50);

`ifdef CHECKSUM_PKT_EN
    // Bad checksum then a good frame.
    e0 = n_pkterr;
    send_frame(8'h03, 3, 1'b1, 1'b0);
    check("chk_err_rise", pkt_err, 1);
    tick();
    check("chk_err_pulse", pkt_err, 0);
    check("chk_err_count", n_pkterr - e0, 1);
    check("chk_err_noval", axiov, 0);
    send_frame(8'h03, 3, 1'b0, 1'b1);
    wait_idle(1'b0, 50);
`endif

    // Stray bytes, then LEN 0 and LEN 65 rejected.
    e0 = n_pkterr;
    send_byte(8'h00);
    send_byte(8'hFF);
    check("stray_busy", busy, 0);
    send_byte(8'hA5);
    send_byte(8'h00);
    check("len0_err", pkt_err, 1);
    check("len0_busy", busy, 0);
    send_byte(8'hA5);
    send_byte(8'h41);
    check("len65_err", pkt_err, 1);
    check("len65_busy", busy, 0);
    tick();
    check("badlen_err_count", n_pkterr - e0, 2);

    // LEN = MAX_LEN with random payload and random backpressure.
    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom_range(0, 255));
    e0 = n_pkterr;
    send_frame(8'h40, 64, 1'b0, 1'b1);
    wait_idle(1'b1, 2000);
    check("maxlen_no_err", n_pkterr - e0, 0);

    // Backpressure pattern 0,1,0,0,1,1 with SYNC bytes thrown in during drain.
    pay[0] = 8'h5A; pay[1] = 8'hC3; pay[2] = 8'h0F;
    e0 = n_pkterr;
    send_frame(8'h03, 3, 1'b0, 1'b1);
    x0 = n_xfer;
    pat = 6'b110010;
    for (int i = 0; i < 6; i++) begin
      axiordy = pat[i];
      axiiv = (i == 1 || i == 2);
      axiid = (i == 1) ? 8'hA5 : 8'h02;
      tick();
    end
    axiiv = 1'b0;
    axiordy = 1'b1;
    check("stall_xfers", n_xfer - x0, 3);
    check("stall_busy", busy, 0);
    check("stall_no_err", n_pkterr - e0, 0);
    wait_idle(1'b0, 20);

    // 99 idle cycles inside a frame are tolerated.
    e0 = n_pkterr;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    repeat (99) tick();
    check("tmo99_no_err", n_pkterr - e0, 0);
    check("tmo99_busy", busy, 1);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    send_byte(8'h22);
`ifdef CHECKSUM_PKT_EN
    send_byte(8'h02 ^ 8'h11 ^ 8'h22);
`endif
    wait_idle(1'b0, 50);

    // Silence expires the frame on the 100th idle cycle.
    e0 = n_pkterr;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (pkt_err) begin
        k = i;
        break;
      end
    end
    check("tmo_cycles", k, 100);
    check("tmo_busy", busy, 0);
    tick();
    check("tmo_err_count", n_pkterr - e0, 1);

    // Reset during drain after the first byte.
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
    e0 = n_pkterr;
    send_frame(8'h03, 3, 1'b0, 1'b1);
    tick();
    check("rstd_axiov_up", axiov, 1);
    tick();
    rst = 1'b1;
    tick();
    check("rstd_axiov", axiov, 0);
    check("rstd_busy", busy, 0);
    check("rstd_pkt_err", pkt_err, 0);
    rst = 1'b0;
    exp_q.delete();
    pay[0] = 8'h7E;
    send_frame(8'h01, 1, 1'b0, 1'b1);
    wait_idle(1'b0, 20);
    check("rstd_no_err", n_pkterr - e0, 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
